// File: rtl/down_counter_ctrl_if.sv
// ---------------------------------------------------------------------------
// down_counter_ctrl_if
// Groups the control and status signals of down_counter_ctrl.
//   load_val  : start value, sampled on an accepted start
//   start     : single-cycle start/restart request
//   pause     : level, holds the countdown while high
//   abort     : single-cycle abort request
//   reload_en : (AUTO_RELOAD_EN only) reload on terminal count
//   count     : current counter value
//   busy      : high in RUN or PAUSE
//   done      : one-cycle terminal-count pulse
//   state     : IDLE=00, RUN=01, PAUSE=10, DONE=11
// Modports: master drives the requests, slave is the counter controller.
// Optional feature macro: AUTO_RELOAD_EN
// ---------------------------------------------------------------------------
interface down_counter_ctrl_if #(
    parameter int unsigned WIDTH = 5
);
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             pause;
    logic             abort;
`ifdef AUTO_RELOAD_EN
    logic             reload_en;
`endif
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic [1:0]       state;

`ifdef AUTO_RELOAD_EN
    modport master (
        output load_val, start, pause, abort, reload_en,
        input  count, busy, done, state
    );
    modport slave (
        input  load_val, start, pause, abort, reload_en,
        output count, busy, done, state
    );
`else
    modport master (
        output load_val, start, pause, abort,
        input  count, busy, done, state
    );
    modport slave (
        input  load_val, start, pause, abort,
        output count, busy, done, state
    );
`endif
endinterface

// File: rtl/down_counter_ctrl.sv
// ---------------------------------------------------------------------------
// down_counter_ctrl
// Sequences a WIDTH-bit programmable down counter: load, decrement once per
// prescaler tick, pause/resume, abort, one-cycle done pulse on terminal count.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : down_counter_ctrl_if.slave (load_val/start/pause/abort[/reload_en]
//           in, count/busy/done/state out; all outputs registered)
// Parameters:
//   WIDTH    : counter width
//   PRESCALE : clock cycles per count step (>=1)
// Optional feature macro: AUTO_RELOAD_EN (adds reload_en; reload on terminal
// count instead of entering DONE).
// ---------------------------------------------------------------------------
module down_counter_ctrl #(
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned PRESCALE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    down_counter_ctrl_if.slave   bus
);

    localparam int unsigned    PSW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [PSW-1:0]   presc_q, presc_d;
    logic             done_q,  done_d;
    logic             busy_q,  busy_d;

    logic             active;
    logic             advancing;
    logic             tick;
    logic             terminal;
    logic             reload_ok;

    // A cycle in PAUSE with pause already low behaves as a RUN cycle, so
    // every cycle with pause high costs exactly one cycle of countdown.
    assign active    = (state_q == RUN) || (state_q == PAUSE);
    assign advancing = active && !bus.pause;
    assign tick      = advancing && (presc_q == PS_LAST);
    assign terminal  = tick && (count_q == WIDTH'(1));

`ifdef AUTO_RELOAD_EN
    assign reload_ok = bus.reload_en && (bus.load_val != '0);
`else
    assign reload_ok = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: abort > start > pause
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.start) begin
                    state_d = (bus.load_val == '0) ? DONE : RUN;
                end
            end
            RUN, PAUSE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.start) begin
                    state_d = (bus.load_val == '0) ? DONE : RUN;
                end else if (bus.pause) begin
                    state_d = PAUSE;
                end else if (terminal) begin
                    state_d = reload_ok ? RUN : DONE;
                end else begin
                    state_d = RUN;
                end
            end
        endcase
    end

    // Datapath / output next values
    always_comb begin
        count_d = count_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        if (bus.abort) begin
            count_d = '0;
            presc_d = '0;
        end else if (bus.start) begin
            count_d = bus.load_val;
            presc_d = '0;
            done_d  = (bus.load_val == '0);
        end else if (tick) begin
            presc_d = '0;
            if (terminal) begin
                done_d  = 1'b1;
                count_d = reload_ok ? bus.load_val : '0;
            end else if (count_q != '0) begin
                count_d = count_q - WIDTH'(1);
            end
        end else if (advancing) begin
            presc_d = presc_q + PSW'(1);
        end
        busy_d = (state_d == RUN) || (state_d == PAUSE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            presc_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            presc_q <= presc_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_down_counter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_down_counter_ctrl
// Bench for down_counter_ctrl: one instance with PRESCALE=1 (dut_a) and one
// with PRESCALE=3 (dut_b). Expected observations are queued as each cycle's
// stimulus is driven and popped after the following clock edge.
// ---------------------------------------------------------------------------
module tb_down_counter_ctrl;

    localparam int unsigned W = 5;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic [1:0]   st;
        logic         dn;
        logic         bz;
    } obs_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    obs_t sb[$];

    down_counter_ctrl_if #(.WIDTH(W)) ifa ();
    down_counter_ctrl_if #(.WIDTH(W)) ifb ();

    down_counter_ctrl #(.WIDTH(W), .PRESCALE(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    down_counter_ctrl #(.WIDTH(W), .PRESCALE(3)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input int unsigned c, input int unsigned s,
                                input int unsigned d, input int unsigned b);
        return {W'(c), 2'(s), 1'(d), 1'(b)};
    endfunction

    task automatic step_a(output obs_t o);
        @(posedge clk);
        #1;
        o = {ifa.count, ifa.state, ifa.done, ifa.busy};
    endtask

    task automatic step_b(output obs_t o);
        @(posedge clk);
        #1;
        o = {ifb.count, ifb.state, ifb.done, ifb.busy};
    endtask

    task automatic drive_a(input int unsigned s, input int unsigned p,
                           input int unsigned a, input int unsigned lv);
        ifa.start    = 1'(s);
        ifa.pause    = 1'(p);
        ifa.abort    = 1'(a);
        ifa.load_val = W'(lv);
    endtask

    task automatic test_reset;
        obs_t o;
        reset = 1'b0;
        drive_a(0, 0, 0, 0);
        ifb.start = 1'b0; ifb.pause = 1'b0; ifb.abort = 1'b0; ifb.load_val = '0;
`ifdef AUTO_RELOAD_EN
        ifa.reload_en = 1'b0;
        ifb.reload_en = 1'b0;
`endif
        step_a(o);
        checks++;
        if (o !== mk(0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_a: got cnt=%0d st=%b done=%b busy=%b, expected cnt=0 st=00 done=0 busy=0",
                     o.cnt, o.st, o.dn, o.bz);
        end
        checks++;
        if ({ifb.count, ifb.state, ifb.done, ifb.busy} !== mk(0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_b: got cnt=%0d st=%b done=%b busy=%b, expected all zero",
                     ifb.count, ifb.state, ifb.done, ifb.busy);
        end
        reset = 1'b1;
    endtask

    task automatic test_reset_mid_run;
        obs_t o;
        drive_a(1, 0, 0, 9);
        step_a(o);
        drive_a(0, 0, 0, 9);
        step_a(o);
        step_a(o);
        checks++;
        if (o !== mk(7, 1, 0, 1)) begin
            errors++;
            $display("FAIL mid_run_pre: got cnt=%0d st=%b, expected cnt=7 st=01", o.cnt, o.st);
        end
        #2;
        reset = 1'b0;
        #1;
        o = {ifa.count, ifa.state, ifa.done, ifa.busy};
        checks++;
        if (o !== mk(0, 0, 0, 0)) begin
            errors++;
            $display("FAIL async_reset: got cnt=%0d st=%b done=%b busy=%b, expected all zero",
                     o.cnt, o.st, o.dn, o.bz);
        end
        reset = 1'b1;
    endtask

    task automatic test_count_p1;
        int unsigned stim [7][4] = '{'{1,0,0,5}, '{0,0,0,5}, '{0,0,0,5}, '{0,0,0,5},
                                     '{0,0,0,5}, '{0,0,0,5}, '{0,0,0,5}};
        int unsigned expv [7][4] = '{'{5,1,0,1}, '{4,1,0,1}, '{3,1,0,1}, '{2,1,0,1},
                                     '{1,1,0,1}, '{0,3,1,0}, '{0,3,0,0}};
        obs_t o, e;
        for (int i = 0; i < 7; i++) begin
            drive_a(stim[i][0], stim[i][1], stim[i][2], stim[i][3]);
            sb.push_back(mk(expv[i][0], expv[i][1], expv[i][2], expv[i][3]));
            step_a(o);
            e = sb.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL count_p1[%0d]: got cnt=%0d st=%b done=%b busy=%b, expected cnt=%0d st=%b done=%b busy=%b",
                         i, o.cnt, o.st, o.dn, o.bz, e.cnt, e.st, e.dn, e.bz);
            end
        end
    endtask

    task automatic test_prescale;
        int unsigned expv [8][4] = '{'{2,1,0,1}, '{2,1,0,1}, '{2,1,0,1}, '{1,1,0,1},
                                     '{1,1,0,1}, '{1,1,0,1}, '{0,3,1,0}, '{0,3,0,0}};
        obs_t o, e;
        for (int i = 0; i < 8; i++) begin
            ifb.start    = (i == 0);
            ifb.load_val = W'(2);
            sb.push_back(mk(expv[i][0], expv[i][1], expv[i][2], expv[i][3]));
            step_b(o);
            e = sb.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL prescale3[%0d]: got cnt=%0d st=%b done=%b busy=%b, expected cnt=%0d st=%b done=%b busy=%b",
                         i, o.cnt, o.st, o.dn, o.bz, e.cnt, e.st, e.dn, e.bz);
            end
        end
        ifb.start = 1'b0;
    endtask

    task automatic test_pause;
        int unsigned stim [12][4] = '{'{1,0,0,6}, '{0,0,0,6}, '{0,0,0,6}, '{0,0,0,6},
                                      '{0,1,0,6}, '{0,1,0,6}, '{0,1,0,6}, '{0,1,0,6},
                                      '{0,0,0,6}, '{0,0,0,6}, '{0,0,0,6}, '{0,0,0,6}};
        int unsigned expv [12][4] = '{'{6,1,0,1}, '{5,1,0,1}, '{4,1,0,1}, '{3,1,0,1},
                                      '{3,2,0,1}, '{3,2,0,1}, '{3,2,0,1}, '{3,2,0,1},
                                      '{2,1,0,1}, '{1,1,0,1}, '{0,3,1,0}, '{0,3,0,0}};
        obs_t o, e;
        for (int i = 0; i < 12; i++) begin
            drive_a(stim[i][0], stim[i][1], stim[i][2], stim[i][3]);
            sb.push_back(mk(expv[i][0], expv[i][1], expv[i][2], expv[i][3]));
            step_a(o);
            e = sb.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL pause[%0d]: got cnt=%0d st=%b done=%b busy=%b, expected cnt=%0d st=%b done=%b busy=%b",
                         i, o.cnt, o.st, o.dn, o.bz, e.cnt, e.st, e.dn, e.bz);
            end
        end
    endtask

    task automatic test_abort;
        int unsigned stim [12][4] = '{'{1,0,0,8}, '{0,0,0,8}, '{0,0,0,8}, '{0,0,0,8},
                                      '{0,0,0,8}, '{0,0,1,8}, '{0,0,0,8}, '{1,0,0,8},
                                      '{0,0,0,8}, '{1,0,1,3}, '{0,0,0,3}, '{1,0,1,3}};
        int unsigned expv [12][4] = '{'{8,1,0,1}, '{7,1,0,1}, '{6,1,0,1}, '{5,1,0,1},
                                      '{4,1,0,1}, '{0,0,0,0}, '{0,0,0,0}, '{8,1,0,1},
                                      '{7,1,0,1}, '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}};
        obs_t o, e;
        for (int i = 0; i < 12; i++) begin
            drive_a(stim[i][0], stim[i][1], stim[i][2], stim[i][3]);
            sb.push_back(mk(expv[i][0], expv[i][1], expv[i][2], expv[i][3]));
            step_a(o);
            e = sb.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL abort[%0d]: got cnt=%0d st=%b done=%b busy=%b, expected cnt=%0d st=%b done=%b busy=%b",
                         i, o.cnt, o.st, o.dn, o.bz, e.cnt, e.st, e.dn, e.bz);
            end
        end
    endtask

    task automatic test_back_to_back;
        int unsigned stim [9][4] = '{'{1,0,0,0}, '{0,0,0,0}, '{1,0,0,4}, '{0,0,0,4},
                                     '{1,1,0,6}, '{0,1,0,6}, '{0,0,0,6}, '{0,0,1,6},
                                     '{0,0,0,6}};
        int unsigned expv [9][4] = '{'{0,3,1,0}, '{0,3,0,0}, '{4,1,0,1}, '{3,1,0,1},
                                     '{6,1,0,1}, '{6,2,0,1}, '{5,1,0,1}, '{0,0,0,0},
                                     '{0,0,0,0}};
        obs_t o, e;
        for (int i = 0; i < 9; i++) begin
            drive_a(stim[i][0], stim[i][1], stim[i][2], stim[i][3]);
            sb.push_back(mk(expv[i][0], expv[i][1], expv[i][2], expv[i][3]));
            step_a(o);
            e = sb.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got cnt=%0d st=%b done=%b busy=%b, expected cnt=%0d st=%b done=%b busy=%b",
                         i, o.cnt, o.st, o.dn, o.bz, e.cnt, e.st, e.dn, e.bz);
            end
        end
    endtask

`ifdef AUTO_RELOAD_EN
    task automatic test_auto_reload;
        int unsigned stim [13][5] = '{'{1,0,0,3,1}, '{0,0,0,3,1}, '{0,0,0,3,1}, '{0,0,0,3,1},
                                      '{0,0,0,3,1}, '{0,0,0,3,1}, '{0,0,0,3,1}, '{0,0,0,3,0},
                                      '{0,0,0,3,0}, '{0,0,0,3,0}, '{0,0,0,3,0}, '{1,0,0,0,0},
                                      '{0,0,0,0,0}};
        int unsigned expv [13][4] = '{'{3,1,0,1}, '{2,1,0,1}, '{1,1,0,1}, '{3,1,1,1},
                                      '{2,1,0,1}, '{1,1,0,1}, '{3,1,1,1}, '{2,1,0,1},
                                      '{1,1,0,1}, '{0,3,1,0}, '{0,3,0,0}, '{0,3,1,0},
                                      '{0,3,0,0}};
        obs_t o, e;
        for (int i = 0; i < 13; i++) begin
            drive_a(stim[i][0], stim[i][1], stim[i][2], stim[i][3]);
            ifa.reload_en = 1'(stim[i][4]);
            sb.push_back(mk(expv[i][0], expv[i][1], expv[i][2], expv[i][3]));
            step_a(o);
            e = sb.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL auto_reload[%0d]: got cnt=%0d st=%b done=%b busy=%b, expected cnt=%0d st=%b done=%b busy=%b",
                         i, o.cnt, o.st, o.dn, o.bz, e.cnt, e.st, e.dn, e.bz);
            end
        end
        ifa.reload_en = 1'b0;
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_reset_mid_run();
        test_count_p1();
        test_prescale();
        test_pause();
        test_abort();
        test_back_to_back();
`ifdef AUTO_RELOAD_EN
        test_auto_reload();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected completion before 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
